// File: rtl/zr_icb2mem_if.sv
// Bus bundles for the ICB-to-memory bridge: an ICB command/response port and a
// zeroriscy-style req/gnt/rvalid memory port, each with master and slave views.
interface zr_icb_if #(parameter int AW = 32);
    logic          icb_cmd_valid;
    logic          icb_cmd_ready;
    logic [AW-1:0] icb_cmd_addr;
    logic          icb_cmd_read;
    logic [31:0]   icb_cmd_wdata;
    logic [3:0]    icb_cmd_wmask;
    logic          icb_rsp_valid;
    logic          icb_rsp_ready;
    logic [31:0]   icb_rsp_rdata;
    logic          icb_rsp_err;

    modport master (
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
        output icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
    );
    modport slave (
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
        input  icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
    );
endinterface

interface zr_mem_if #(parameter int AW = 32);
    logic          mem_req_o;
    logic          mem_gnt_i;
    logic          mem_rvalid_i;
    logic          mem_we_o;
    logic [3:0]    mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i;
    logic          mem_err_i;

    modport master (
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
    );
    modport slave (
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
    );
endinterface

// File: rtl/zr_icb2mem.sv
// ICB responder that replays each command as a req/gnt/rvalid memory transaction
// and returns the memory responses in order through a credit-limited FIFO.
module zr_icb2mem #(
    parameter int AW        = 32,
    parameter int RSP_DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    zr_icb_if.slave   icb,
    zr_mem_if.master  mem
);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int SW = CW + 1;
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          read;
        logic [31:0]   wdata;
        logic [3:0]    wmask;
    } cmd_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic                 cmd_vld_q, cmd_vld_d;
    cmd_t                 cmd_q, cmd_d;
    logic [CW-1:0]        out_cnt_q, out_cnt_d;
    logic [CW-1:0]        fifo_cnt_q, fifo_cnt_d;
    logic [RSP_DEPTH-1:0] typ_q, typ_d;
    logic [PW-1:0]        typ_wp_q, typ_wp_d, typ_rp_q, typ_rp_d;
    logic [PW-1:0]        rsp_wp_q, rsp_wp_d, rsp_rp_q, rsp_rp_d;
    rsp_t                 rsp_mem_q [RSP_DEPTH];
    rsp_t                 rsp_mem_d [RSP_DEPTH];

    logic          pop, push, credit_ok, req, issue, cmd_ready;
    logic [SW-1:0] credit_sum;
    rsp_t          head;

    // A pop this cycle frees a slot immediately, so the request can recover without a bubble.
    assign pop        = icb.icb_rsp_ready & (fifo_cnt_q != '0);
    assign push       = mem.mem_rvalid_i & (out_cnt_q != '0);
    assign credit_sum = (SW'(out_cnt_q) + SW'(fifo_cnt_q)) - SW'(pop);
    assign credit_ok  = credit_sum < SW'(RSP_DEPTH);
    assign req        = cmd_vld_q & credit_ok;
    assign issue      = req & mem.mem_gnt_i;
    assign cmd_ready  = ~cmd_vld_q | issue;
    assign head       = rsp_mem_q[rsp_rp_q];

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
        cmd_vld_d  = cmd_vld_q;
        cmd_d      = cmd_q;
        out_cnt_d  = out_cnt_q;
        fifo_cnt_d = fifo_cnt_q;
        typ_d      = typ_q;
        typ_wp_d   = typ_wp_q;
        typ_rp_d   = typ_rp_q;
        rsp_wp_d   = rsp_wp_q;
        rsp_rp_d   = rsp_rp_q;
        rsp_mem_d  = rsp_mem_q;

        if (icb.icb_cmd_valid & cmd_ready) begin
            cmd_vld_d = 1'b1;
            cmd_d     = '{addr: icb.icb_cmd_addr, read: icb.icb_cmd_read,
                          wdata: icb.icb_cmd_wdata, wmask: icb.icb_cmd_wmask};
        end else if (issue) begin
            cmd_vld_d = 1'b0;
        end

        if (issue & ~push)      out_cnt_d = out_cnt_q + CW'(1);
        else if (~issue & push) out_cnt_d = out_cnt_q - CW'(1);

        // The type bit of each granted command waits here until its rvalid returns.
        if (issue) begin
            typ_d[typ_wp_q] = cmd_q.read;
            typ_wp_d        = ptr_inc(typ_wp_q);
        end
        if (push) begin
            typ_rp_d                = ptr_inc(typ_rp_q);
            rsp_mem_d[rsp_wp_q]     = '{rdata: typ_q[typ_rp_q] ? mem.mem_rdata_i : 32'h0,
                                        err:   mem.mem_err_i};
            rsp_wp_d                = ptr_inc(rsp_wp_q);
        end
        if (pop) rsp_rp_d = ptr_inc(rsp_rp_q);

        if (push & ~pop)      fifo_cnt_d = fifo_cnt_q + CW'(1);
        else if (~push & pop) fifo_cnt_d = fifo_cnt_q - CW'(1);
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_vld_q  <= 1'b0;
            cmd_q      <= '0;
            out_cnt_q  <= '0;
            fifo_cnt_q <= '0;
            typ_q      <= '0;
            typ_wp_q   <= '0;
            typ_rp_q   <= '0;
            rsp_wp_q   <= '0;
            rsp_rp_q   <= '0;
        end else begin
            cmd_vld_q  <= cmd_vld_d;
            cmd_q      <= cmd_d;
            out_cnt_q  <= out_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            typ_q      <= typ_d;
            typ_wp_q   <= typ_wp_d;
            typ_rp_q   <= typ_rp_d;
            rsp_wp_q   <= rsp_wp_d;
            rsp_rp_q   <= rsp_rp_d;
        end
    end

    // NOTE: response storage has no reset; an entry is only observed after a push, and the
    // output is forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        rsp_mem_q <= rsp_mem_d;
    end

    assign icb.icb_cmd_ready = cmd_ready;
    assign icb.icb_rsp_valid = (fifo_cnt_q != '0);
    assign icb.icb_rsp_rdata = (fifo_cnt_q != '0) ? head.rdata : 32'h0;
    assign icb.icb_rsp_err   = (fifo_cnt_q != '0) & head.err;

    // Memory-side fields are zero whenever the command stage is empty.
    assign mem.mem_req_o   = req;
    assign mem.mem_addr_o  = cmd_vld_q ? (cmd_q.addr & ~AW'(3)) : '0;
    assign mem.mem_we_o    = cmd_vld_q & ~cmd_q.read;
    assign mem.mem_be_o    = cmd_vld_q ? (cmd_q.read ? 4'hF : cmd_q.wmask) : 4'h0;
    assign mem.mem_wdata_o = cmd_vld_q ? cmd_q.wdata : 32'h0;
endmodule

// File: tb/tb_zr_icb2mem.sv
// Self-checking bench for zr_icb2mem: a TCM-like responder (gnt combinational,
// rvalid one cycle after grant) plus directed vectors and corner sequences.
module tb_zr_icb2mem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    zr_icb_if #(.AW(32)) icb ();
    zr_mem_if #(.AW(32)) mem ();

    zr_icb2mem #(.AW(32), .RSP_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .icb (icb),
        .mem (mem)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory responder
    logic [31:0] ram [64];
    logic        load_ram = 1'b1;
    logic        gnt_en   = 1'b1;
    logic        err_flag = 1'b0;
    logic        spur_rv  = 1'b0;
    logic        m_rv     = 1'b0;
    logic        m_err    = 1'b0;
    logic [31:0] m_rdata  = 32'h0;
    int          grant_cnt = 0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 1) return 32'hDEAD_BEEF;
        if (i >= 32 && i < 40) return 32'hC0DE_0000 | 32'(i - 32);
        return 32'h0;
    endfunction

    assign mem.mem_gnt_i    = gnt_en;
    assign mem.mem_rvalid_i = m_rv | spur_rv;
    assign mem.mem_rdata_i  = m_rdata;
    assign mem.mem_err_i    = m_err;

    always @(posedge clk) begin
        m_rv <= mem.mem_req_o & gnt_en;
        if (load_ram) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
        end else if (mem.mem_req_o & gnt_en) begin
            grant_cnt <= grant_cnt + 1;
            m_err     <= err_flag;
            if (mem.mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem.mem_be_o[b])
                        ram[mem.mem_addr_o[7:2]][8*b +: 8] <= mem.mem_wdata_o[8*b +: 8];
                m_rdata <= 32'hBAD0_BAD0;
            end else begin
                m_rdata <= ram[mem.mem_addr_o[7:2]];
            end
        end
    end

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];
    logic [31:0] exp_rdata_q [$];
    logic        exp_err_q   [$];

    task automatic check_reset_outputs(input string p);
        check({p, "_cmd_ready"}, icb.icb_cmd_ready, 1);
        check({p, "_rsp_valid"}, icb.icb_rsp_valid, 0);
        check({p, "_rsp_rdata"}, icb.icb_rsp_rdata, 0);
        check({p, "_rsp_err"},   icb.icb_rsp_err,   0);
        check({p, "_req"},       mem.mem_req_o,     0);
        check({p, "_we"},        mem.mem_we_o,      0);
        check({p, "_be"},        mem.mem_be_o,      0);
        check({p, "_addr"},      mem.mem_addr_o,    0);
        check({p, "_wdata"},     mem.mem_wdata_o,   0);
    endtask

    // Single transaction with rsp_ready=1, gnt=1; starts and ends on a falling edge.
    task automatic run_vec(input vec_t v, input int k);
        icb.icb_cmd_read  = v.rd;
        icb.icb_cmd_addr  = v.addr;
        icb.icb_cmd_wdata = v.wdata;
        icb.icb_cmd_wmask = v.wmask;
        icb.icb_cmd_valid = 1'b1;
        #1 check($sformatf("v%0d_cmd_ready", k), icb.icb_cmd_ready, 1);
        @(negedge clk);
        icb.icb_cmd_valid = 1'b0;
        #1;
        check($sformatf("v%0d_req", k),   mem.mem_req_o,   1);
        check($sformatf("v%0d_addr", k),  mem.mem_addr_o,  v.exp_addr);
        check($sformatf("v%0d_we", k),    mem.mem_we_o,    v.exp_we);
        check($sformatf("v%0d_be", k),    mem.mem_be_o,    v.exp_be);
        check($sformatf("v%0d_wdata", k), mem.mem_wdata_o, v.wdata);
        @(negedge clk);
        #1 check($sformatf("v%0d_rsp_early", k), icb.icb_rsp_valid, 0);
        @(negedge clk);
        #1;
        check($sformatf("v%0d_rsp_valid", k), icb.icb_rsp_valid, 1);
        check($sformatf("v%0d_rsp_rdata", k), icb.icb_rsp_rdata, v.exp_rdata);
        check($sformatf("v%0d_rsp_err", k),   icb.icb_rsp_err,   0);
        @(negedge clk);
    endtask

    task automatic send(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wmask);
        logic acc = 1'b0;
        icb.icb_cmd_read  = rd;
        icb.icb_cmd_addr  = addr;
        icb.icb_cmd_wdata = wdata;
        icb.icb_cmd_wmask = wmask;
        icb.icb_cmd_valid = 1'b1;
        for (int c = 0; c < 20 && !acc; c++) begin
            #1 acc = icb.icb_cmd_ready;
            @(negedge clk);
        end
        icb.icb_cmd_valid = 1'b0;
        check("send_accept", acc, 1);
    endtask

    task automatic collect(input int n, input int bound);
        int got = 0;
        for (int c = 0; c < bound && got < n; c++) begin
            #2;
            if (icb.icb_rsp_valid && icb.icb_rsp_ready) begin
                check($sformatf("rsp%0d_rdata", got), icb.icb_rsp_rdata, exp_rdata_q.pop_front());
                check($sformatf("rsp%0d_err", got),   icb.icb_rsp_err,   exp_err_q.pop_front());
                got++;
            end
            @(negedge clk);
        end
        check("rsp_count", got, n);
    endtask

    initial begin
        int base;
        vecs[0] = '{1'b1, 32'h8000_0006, 32'h0,         4'h0, 32'h8000_0004, 1'b0, 4'hF, 32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 32'h8000_0010, 32'h1234_5678, 4'h3, 32'h8000_0010, 1'b1, 4'h3, 32'h0};
        vecs[2] = '{1'b1, 32'h8000_0012, 32'h0,         4'h0, 32'h8000_0010, 1'b0, 4'hF, 32'h0000_5678};
        vecs[3] = '{1'b0, 32'h8000_0021, 32'hAABB_CCDD, 4'hC, 32'h8000_0020, 1'b1, 4'hC, 32'h0};
        vecs[4] = '{1'b1, 32'h8000_0020, 32'h0,         4'h0, 32'h8000_0020, 1'b0, 4'hF, 32'hAABB_0000};
        vecs[5] = '{1'b0, 32'h8000_0007, 32'h0011_0000, 4'h4, 32'h8000_0004, 1'b1, 4'h4, 32'h0};
        vecs[6] = '{1'b1, 32'h8000_0004, 32'h0,         4'h0, 32'h8000_0004, 1'b0, 4'hF, 32'hDE11_BEEF};

        icb.icb_cmd_valid = 1'b0;
        icb.icb_cmd_read  = 1'b0;
        icb.icb_cmd_addr  = 32'h0;
        icb.icb_cmd_wdata = 32'h0;
        icb.icb_cmd_wmask = 4'h0;
        icb.icb_rsp_ready = 1'b1;

        @(negedge clk);
        #1 check_reset_outputs("por");
        @(negedge clk);
        rst      = 1'b0;
        load_ram = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Eight back-to-back reads: one response per cycle, three cycles behind.
        for (int c = 0; c < 11; c++) begin
            if (c < 8) begin
                icb.icb_cmd_read  = 1'b1;
                icb.icb_cmd_addr  = 32'h8000_0080 + 32'(4 * c);
                icb.icb_cmd_valid = 1'b1;
            end else begin
                icb.icb_cmd_valid = 1'b0;
            end
            #1;
            if (c < 8) check($sformatf("b2b%0d_cmd_ready", c), icb.icb_cmd_ready, 1);
            if (c >= 3) begin
                check($sformatf("b2b%0d_rsp_valid", c - 3), icb.icb_rsp_valid, 1);
                check($sformatf("b2b%0d_rsp_rdata", c - 3), icb.icb_rsp_rdata,
                      32'hC0DE_0000 | 32'(c - 3));
            end
            @(negedge clk);
        end
        #1 check("b2b_drained", icb.icb_rsp_valid, 0);
        @(negedge clk);

        // Response backpressure with two credits.
        icb.icb_rsp_ready = 1'b0;
        base = grant_cnt;
        send(1'b1, 32'h8000_0080, 32'h0, 4'h0);
        send(1'b1, 32'h8000_0084, 32'h0, 4'h0);
        send(1'b1, 32'h8000_0088, 32'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("bp_grants",    grant_cnt - base,   2);
        check("bp_req_held",  mem.mem_req_o,      0);
        check("bp_cmd_ready", icb.icb_cmd_ready,  0);
        check("bp_rsp_valid", icb.icb_rsp_valid,  1);
        check("bp_head",      icb.icb_rsp_rdata,  32'hC0DE_0000);
        icb.icb_rsp_ready = 1'b1;
        #1 check("bp_req_recover", mem.mem_req_o, 1);
        for (int i = 0; i < 4; i++) begin
            exp_rdata_q.push_back(32'hC0DE_0000 | 32'(i));
            exp_err_q.push_back(1'b0);
        end
        fork
            send(1'b1, 32'h8000_008C, 32'h0, 4'h0);
            collect(4, 30);
        join

        // Grant withheld three cycles, then an error response.
        gnt_en   = 1'b0;
        err_flag = 1'b1;
        send(1'b1, 32'h8000_0084, 32'h0, 4'h0);
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) gnt_en = 1'b1;
            #1;
            check($sformatf("stall%0d_req", i),       mem.mem_req_o,     1);
            check($sformatf("stall%0d_addr", i),      mem.mem_addr_o,    32'h8000_0084);
            check($sformatf("stall%0d_we", i),        mem.mem_we_o,      0);
            check($sformatf("stall%0d_be", i),        mem.mem_be_o,      4'hF);
            check($sformatf("stall%0d_cmd_ready", i), icb.icb_cmd_ready, (i == 4));
            @(negedge clk);
        end
        exp_rdata_q.push_back(32'hC0DE_0001);
        exp_err_q.push_back(1'b1);
        collect(1, 10);
        err_flag = 1'b0;

        // Reset with one response queued and one transaction in flight.
        icb.icb_rsp_ready = 1'b0;
        send(1'b1, 32'h8000_0090, 32'h0, 4'h0);
        send(1'b1, 32'h8000_0094, 32'h0, 4'h0);
        @(negedge clk);
        #1 check("pre_rst_rsp_valid", icb.icb_rsp_valid, 1);
        rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst     = 1'b0;
        spur_rv = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) spur_rv = 1'b0;
            #1;
            check($sformatf("post_rst%0d_rsp_valid", c), icb.icb_rsp_valid, 0);
            check($sformatf("post_rst%0d_req", c),       mem.mem_req_o,     0);
            @(negedge clk);
        end
        icb.icb_rsp_ready = 1'b1;
        run_vec(vecs[6], 7);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
